// File: rtl/opp_state_rx.sv
// Opponent kart state receiver: parses 10-byte packets, validates length, checksum,
// field ranges and sequence freshness, then commits the fields atomically.
module opp_state_rx #(
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int          PKT_BYTES      = 10,
    parameter int          TIMEOUT_CYCLES = 6_500_000,
    parameter logic [10:0] INIT_X         = 11'd256,
    parameter logic [10:0] INIT_Y         = 11'd272
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        axiiv,
    input  logic [7:0]  axiid,
    output logic [10:0] r_opp_x,
    output logic [10:0] r_opp_y,
    output logic [8:0]  r_opp_dir,
    output logic [2:0]  r_opp_game,
    output logic        r_opp_rst,
    output logic        receive_axiiv,
    output logic        link_lost,
    output logic [7:0]  err_count
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]  LAST_IDX = 4'(PKT_BYTES);

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t        state, state_nx;
    logic [3:0]    idx;
    logic [7:0]    xsum;
    logic [7:0]    sh_seq, sh_x_hi, sh_x_lo, sh_y_hi, sh_y_lo, sh_dir_hi, sh_dir_lo, sh_ctl;
    logic [7:0]    last_seq;
    logic          seq_seen;
    logic [TW-1:0] tmo_cnt, tmo_nx;

    logic          start, take, eval, drop_end;
    logic [8:0]    dir_val;
    logic [7:0]    seq_diff;
    logic          fields_ok, fresh, pkt_good, pkt_bad;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        take     = 1'b0;
        eval     = 1'b0;
        drop_end = 1'b0;
        case (state)
            IDLE: begin
                if (axiiv) begin
                    start    = 1'b1;
                    state_nx = (axiid == MAGIC) ? BODY : DROP;
                end
            end
            BODY: begin
                if (axiiv) begin
                    if (idx == LAST_IDX) state_nx = DROP;
                    else                 take     = 1'b1;
                end else begin
                    eval     = 1'b1;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                if (!axiiv) begin
                    drop_end = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dir_val   = {sh_dir_hi[0], sh_dir_lo};
        fields_ok = (sh_x_hi[7:3] == 5'd0) && (sh_y_hi[7:3] == 5'd0) &&
                    (sh_dir_hi[7:1] == 7'd0) && (dir_val <= 9'd359);
        // Modular difference: 1..127 ahead of the last accepted seq counts as fresh.
        seq_diff  = sh_seq - last_seq;
        fresh     = !seq_seen || ((seq_diff != 8'd0) && !seq_diff[7]);
        pkt_good  = eval && (idx == LAST_IDX) && (xsum == 8'd0) && fields_ok && fresh;
        pkt_bad   = (eval && !pkt_good) || drop_end;

        if (pkt_good)                tmo_nx = '0;
        else if (tmo_cnt == TMO_MAX) tmo_nx = tmo_cnt;
        else                         tmo_nx = tmo_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx           <= 4'd0;
            xsum          <= 8'd0;
            last_seq      <= 8'd0;
            seq_seen      <= 1'b0;
            tmo_cnt       <= '0;
            r_opp_x       <= INIT_X;
            r_opp_y       <= INIT_Y;
            r_opp_dir     <= 9'd0;
            r_opp_game    <= 3'd0;
            r_opp_rst     <= 1'b0;
            receive_axiiv <= 1'b0;
            link_lost     <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            if (start) begin
                idx  <= 4'd1;
                xsum <= axiid;
            end else if (take) begin
                idx  <= idx + 4'd1;
                xsum <= xsum ^ axiid;
            end

            if (pkt_good) begin
                r_opp_x    <= {sh_x_hi[2:0], sh_x_lo};
                r_opp_y    <= {sh_y_hi[2:0], sh_y_lo};
                r_opp_dir  <= dir_val;
                r_opp_game <= sh_ctl[2:0];
                r_opp_rst  <= sh_ctl[3];
                last_seq   <= sh_seq;
                seq_seen   <= 1'b1;
            end
            receive_axiiv <= pkt_good;

            if (pkt_bad && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            tmo_cnt   <= tmo_nx;
            link_lost <= (tmo_nx == TMO_MAX);
        end
    end

    // NOTE: shadow bytes carry no reset; they only reach the outputs after a full, validated packet rewrote them.
    always_ff @(posedge clk) begin
        if (take) begin
            case (idx)
                4'd1:    sh_seq    <= axiid;
                4'd2:    sh_x_hi   <= axiid;
                4'd3:    sh_x_lo   <= axiid;
                4'd4:    sh_y_hi   <= axiid;
                4'd5:    sh_y_lo   <= axiid;
                4'd6:    sh_dir_hi <= axiid;
                4'd7:    sh_dir_lo <= axiid;
                4'd8:    sh_ctl    <= axiid;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/opp_state_rx.md
Name: opp_state_rx

Overview:
- Upstream stage of the game logic. Parses a byte-wide packet stream from the network receive path into opponent kart state.
- Validates each packet, drops stale or malformed ones, and presents r_opp_x / r_opp_y / r_opp_dir / r_opp_game / r_opp_rst plus a one-cycle update strobe to the game block.
- Flags link loss when no good packet arrives for a programmable interval.

Parameters:
- MAGIC, 8'hA5, required value of byte 0.
- PKT_BYTES, 10, exact packet length in bytes.
- TIMEOUT_CYCLES, 6_500_000, clk cycles without a committed packet before link_lost asserts (100 ms at 65 MHz).
- INIT_X, 256, reset value of r_opp_x.
- INIT_Y, 272, reset value of r_opp_y.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous, active-low.
- axiiv  input  1  byte valid; a high run is one packet, and a low cycle ends it.
- axiid  input  8  packet byte.
- r_opp_x  output  11  opponent x position.
- r_opp_y  output  11  opponent y position.
- r_opp_dir  output  9  opponent heading in degrees, 0..359.
- r_opp_game  output  3  opponent game status.
- r_opp_rst  output  1  opponent reset request.
- receive_axiiv  output  1  one-cycle pulse when outputs update.
- link_lost  output  1  no committed packet for TIMEOUT_CYCLES.
- err_count  output  8  rejected packets, saturating at 255.

Behaviour:
- Reset: all outputs update at the first posedge with rst_n=0.
  - r_opp_x=INIT_X, r_opp_y=INIT_Y.
  - r_opp_dir=0, r_opp_game=0, r_opp_rst=0.
  - receive_axiiv=0, link_lost=0, err_count=0.
  - Timeout counter=0, FSM=IDLE, seq_seen=0.
  - Reset mid-packet discards the packet. Bytes arriving while rst_n=0 are ignored.
- Packet format (big-endian):
  - b0=MAGIC, b1=seq.
  - b2..b3 = x: b2[7:3] must be 0.
  - b4..b5 = y: b4[7:3] must be 0.
  - b6..b7 = dir: b6[7:1] must be 0, and dir must be ≤359.
  - b8: [2:0]=game, [3]=rst, [7:4] ignored.
  - b9 = XOR of b0..b8.
- FSM states: IDLE, BODY, DROP.
  - IDLE: on axiiv=1, go to BODY if axiid==MAGIC; otherwise go to DROP. Byte index starts at 1 and the running XOR is seeded with the byte.
  - BODY: each axiiv=1 byte is stored in a shadow register and folded into the XOR. The index increments.
    - A byte arriving with index==PKT_BYTES means the packet is too long: go to DROP.
    - On axiiv=0, evaluate the packet and return to IDLE.
  - DROP: wait for axiiv=0, increment err_count once, return to IDLE.
- Evaluation on the axiiv=0 edge. The packet is good only if all of the following hold:
  - index==PKT_BYTES;
  - XOR of all 10 bytes ==0;
  - range/zero-bit checks pass;
  - sequence is fresh: either seq_seen==0, or (seq − last_seq) mod 256 is in 1..127.
- Good packet: at that same edge, all five r_opp_* outputs load atomically from the shadow registers.
  - receive_axiiv=1 for exactly that one cycle.
  - last_seq=seq, seq_seen=1, timeout counter cleared, link_lost=0.
- Bad packet (short, bad checksum, range failure, stale or duplicate seq): outputs hold, and err_count+1 (saturating).
- Latency: last byte at edge N, axiiv=0 at edge N+1, outputs and receive_axiiv visible after edge N+1.
- Back-to-back packets need one idle cycle minimum. A new packet may begin on the cycle immediately after the evaluating low cycle.
- Shadow registers never leak partial packets to the outputs.
- Timeout counter:
  - Increments every cycle without a commit and saturates at TIMEOUT_CYCLES.
  - link_lost=1 when the count reaches TIMEOUT_CYCLES.
  - link_lost clears at the next good commit.
  - If a commit coincides with the count reaching the limit, the commit wins and link_lost stays 0.
- Width rules: x, y and dir are assembled as unsigned with no sign extension. The seq difference uses 8-bit modular subtraction.

Test Plan:
- Good packet: after reset send A5,01,00,C8,01,2C,00,5A,00 plus the correct XOR byte, then drop axiiv → one cycle after the drop r_opp_x=200, r_opp_y=300, r_opp_dir=90, receive_axiiv pulses one cycle, err_count=0.
- Checksum corruption: same packet with seq=02 and the last byte XORed with 0x01 → outputs hold at 200/300/90, no pulse, err_count=1.
- Freshness: resend seq=01, then seq=81 (diff 128), then seq=02 → seq=01 and seq=81 rejected (err_count+2); seq=02 accepted with a pulse.
- Length and range: 9-byte packet, 11-byte packet, and dir=360 packet → each rejected; err_count +3; outputs unchanged.
- Link timeout: with TIMEOUT_CYCLES=100, idle 100 cycles → link_lost=1; good packet → link_lost=0 at the commit edge.
- Reset abort: assert rst_n=0 at byte 5 of a good packet → outputs return to 256/272/0, err_count=0. A following good packet commits normally even though its seq is any value.
